floo_offload_alu: RTL and testbench



---
 rtl/floo_offload_pkg.sv | 55 +++++
 rtl/floo_offload_pipe_stage.sv | 45 ++++
 rtl/floo_offload_alu.sv | 98 +++++++++
 tb/tb_floo_offload_alu.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_offload_pkg.sv
// Shared types and the per-lane arithmetic for the offload reduction ALU.
package floo_offload_pkg;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'd0,
      ALU_MIN_S = 3'd1,
      ALU_MAX_S = 3'd2,
      ALU_MIN_U = 3'd3,
      ALU_MAX_U = 3'd4,
      ALU_AND   = 3'd5,
      ALU_OR    = 3'd6,
      ALU_XOR   = 3'd7
   } alu_op_e;

   localparam int unsigned NumAluOps    = 8;
   localparam int unsigned MaxLaneWidth = 64;

   // An op is defined when its encoding falls inside the enumerated range.
   // With a 3-bit op every encoding is defined; this only bites if op widens.
   function automatic logic op_is_legal(alu_op_e op);
      return (32'(op) < NumAluOps);
   endfunction

   // One lane of the ALU. Operands arrive zero-extended to MaxLaneWidth and
   // only the low 'width' bits take part. Signed compares flip the lane sign
   // bit so a plain unsigned compare gives the signed ordering. Ties in
   // MIN/MAX return operand a. Undefined ops produce zero.
   function automatic logic [MaxLaneWidth-1:0] lane_op(
      alu_op_e                 op,
      logic [MaxLaneWidth-1:0] a,
      logic [MaxLaneWidth-1:0] b,
      int unsigned             width
   );
      logic [MaxLaneWidth-1:0] mask, sbit, am, bm, as, bs, res;
      mask = (64'd1 << width) - 64'd1;
      sbit = 64'd1 << (width - 1);
      am   = a & mask;
      bm   = b & mask;
      as   = am ^ sbit;
      bs   = bm ^ sbit;
      case (op)
         ALU_ADD:   res = (am + bm) & mask;
         ALU_MIN_S: res = (bs < as) ? bm : am;
         ALU_MAX_S: res = (bs > as) ? bm : am;
         ALU_MIN_U: res = (bm < am) ? bm : am;
         ALU_MAX_U: res = (bm > am) ? bm : am;
         ALU_AND:   res = am & bm;
         ALU_OR:    res = am | bm;
         ALU_XOR:   res = am ^ bm;
         default:   res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/floo_offload_pipe_stage.sv
// One elastic register stage: loads from upstream whenever it may advance,
// otherwise holds its valid bit and data.
module floo_offload_pipe_stage #(
   parameter int unsigned Width = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             adv_i,
   input  logic             in_valid_i,
   input  logic [Width-1:0] in_data_i,
   output logic             valid_o,
   output logic [Width-1:0] data_o
);

   logic             valid_d, valid_q;
   logic [Width-1:0] data_d, data_q;

   // Next state: on advance take upstream valid; data only changes when new
   // data actually arrives, so an emptied stage keeps its last value.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (adv_i) begin
         valid_d = in_valid_i;
         if (in_valid_i) begin
            data_d = in_data_i;
         end
      end
   end

   // Stage registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/floo_offload_alu.sv
// Pipelined lane-wise reduction ALU behind the router offload port.
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
// are both high; valid never waits on ready, and once resp_valid_o is high
// resp_result_o holds until resp_ready_i is seen. req_ready_o depends on
// resp_ready_i and stage state only, never on req_valid_i.
module floo_offload_alu
   import floo_offload_pkg::*;
#(
   parameter int unsigned DataWidth = 512,
   parameter int unsigned LaneWidth = 64,
   parameter int unsigned NumStages = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [2:0]           req_op_i,
   input  logic [DataWidth-1:0] req_operand1_i,
   input  logic [DataWidth-1:0] req_operand2_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   output logic [DataWidth-1:0] resp_result_o,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic                 busy_o,
   output logic                 illegal_op_o
);

   localparam int unsigned NumLanes = DataWidth / LaneWidth;

   alu_op_e              op;
   logic [DataWidth-1:0] result;
   logic [NumStages-1:0] stg_valid;
   logic [NumStages-1:0] stg_adv;
   logic [NumStages-1:0] stg_in_valid;
   logic [DataWidth-1:0] stg_data    [NumStages];
   logic [DataWidth-1:0] stg_in_data [NumStages];
   logic                 illegal_d, illegal_q;

   assign op = alu_op_e'(req_op_i);

   // Independent lanes; no carry or compare information crosses a lane edge.
   for (genvar i = 0; i < NumLanes; i++) begin : gen_lane
      assign result[i*LaneWidth +: LaneWidth] = LaneWidth'(lane_op(
         op,
         MaxLaneWidth'(req_operand1_i[i*LaneWidth +: LaneWidth]),
         MaxLaneWidth'(req_operand2_i[i*LaneWidth +: LaneWidth]),
         LaneWidth));
   end

   // Advance chain from the output back: a stage may load if it is empty or
   // the stage after it is moving, so a full pipe accepts and drains at once.
   always_comb begin
      stg_adv              = '0;
      stg_adv[NumStages-1] = resp_ready_i | ~stg_valid[NumStages-1];
      for (int k = int'(NumStages) - 2; k >= 0; k--) begin
         stg_adv[k] = ~stg_valid[k] | stg_adv[k+1];
      end
   end

   for (genvar k = 0; k < NumStages; k++) begin : gen_stage
      if (k == 0) begin : gen_first
         assign stg_in_valid[k] = req_valid_i;
         assign stg_in_data[k]  = result;
      end else begin : gen_next
         assign stg_in_valid[k] = stg_valid[k-1];
         assign stg_in_data[k]  = stg_data[k-1];
      end

      floo_offload_pipe_stage #(
         .Width (DataWidth)
      ) u_stage (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .adv_i      (stg_adv[k]),
         .in_valid_i (stg_in_valid[k]),
         .in_data_i  (stg_in_data[k]),
         .valid_o    (stg_valid[k]),
         .data_o     (stg_data[k])
      );
   end

   assign illegal_d = req_valid_i & req_ready_o & ~op_is_legal(op);

   // Illegal-op flag: one-cycle pulse in the cycle after the accept.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end

   assign req_ready_o   = stg_adv[0];
   assign resp_valid_o  = stg_valid[NumStages-1];
   assign resp_result_o = stg_data[NumStages-1];
   assign busy_o        = |stg_valid;
   assign illegal_op_o  = illegal_q;

endmodule

// File: tb/tb_floo_offload_alu.sv
// Bench for floo_offload_alu: a 128/64/2-stage instance driven by directed
// steps and a 32/8/1-stage instance driven by random traffic.
module tb_floo_offload_alu;

   logic clk;
   logic rst;

   // Instance A: DataWidth 128, LaneWidth 64, NumStages 2
   logic [2:0]   a_op;
   logic [127:0] a_opnd1, a_opnd2, a_resp_result;
   logic         a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
   logic         a_busy, a_illegal;

   // Instance B: DataWidth 32, LaneWidth 8, NumStages 1
   logic [2:0]   b_op;
   logic [31:0]  b_opnd1, b_opnd2, b_resp_result;
   logic         b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
   logic         b_busy, b_illegal;

   logic [127:0] a_exp_q[$];
   logic [127:0] b_exp_q[$];

   int           n_cmp = 0;
   int           n_err = 0;

   logic         a_stall_q, b_prev_acc;
   logic [127:0] a_hold_val;
   logic [127:0] hold_v;

   floo_offload_alu #(.DataWidth(128), .LaneWidth(64), .NumStages(2)) u_dut_a (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_op_i       (a_op),
      .req_operand1_i (a_opnd1),
      .req_operand2_i (a_opnd2),
      .req_valid_i    (a_req_valid),
      .req_ready_o    (a_req_ready),
      .resp_result_o  (a_resp_result),
      .resp_valid_o   (a_resp_valid),
      .resp_ready_i   (a_resp_ready),
      .busy_o         (a_busy),
      .illegal_op_o   (a_illegal)
   );

   floo_offload_alu #(.DataWidth(32), .LaneWidth(8), .NumStages(1)) u_dut_b (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_op_i       (b_op),
      .req_operand1_i (b_opnd1),
      .req_operand2_i (b_opnd2),
      .req_valid_i    (b_req_valid),
      .req_ready_o    (b_req_ready),
      .resp_result_o  (b_resp_result),
      .resp_valid_o   (b_resp_valid),
      .resp_ready_i   (b_resp_ready),
      .busy_o         (b_busy),
      .illegal_op_o   (b_illegal)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic longint sx(logic [63:0] v, int lw);
      if (lw >= 64) return $signed(v);
      if (v[lw-1]) return $signed(v) - (longint'(1) << lw);
      return $signed(v);
   endfunction

   function automatic logic [127:0] model(int lw, int nl, logic [2:0] op,
                                          logic [127:0] a, logic [127:0] b);
      logic [127:0] r;
      logic [63:0]  mask, la, lb, lr;
      longint       sa, sb;
      r    = '0;
      mask = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
      for (int i = 0; i < nl; i++) begin
         la = 64'(a >> (i * lw)) & mask;
         lb = 64'(b >> (i * lw)) & mask;
         sa = sx(la, lw);
         sb = sx(lb, lw);
         case (op)
            3'd0: lr = (la + lb) & mask;
            3'd1: lr = (sb < sa) ? lb : la;
            3'd2: lr = (sb > sa) ? lb : la;
            3'd3: lr = (lb < la) ? lb : la;
            3'd4: lr = (lb > la) ? lb : la;
            3'd5: lr = la & lb;
            3'd6: lr = la | lb;
            default: lr = la ^ lb;
         endcase
         r = r | (128'(lr) << (i * lw));
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard / monitor A ----------------
   always @(negedge clk) begin
      if (rst) begin
         a_stall_q <= 1'b0;
      end else begin
         check("a_illegal", a_illegal, 1'b0);
         if (a_stall_q) check("a_hold_stable", a_resp_result, a_hold_val);
         if (a_resp_valid && a_resp_ready) begin
            n_cmp++;
            assert (a_exp_q.size() > 0) else begin
               n_err++;
               $error("FAIL a_unexpected_resp observed=%0h expected=none", a_resp_result);
            end
            if (a_exp_q.size() > 0) check("a_result", a_resp_result, a_exp_q.pop_front());
         end
         if (a_req_valid && a_req_ready)
            a_exp_q.push_back(model(64, 2, a_op, a_opnd1, a_opnd2));
         a_stall_q  <= a_resp_valid && !a_resp_ready;
         a_hold_val <= a_resp_result;
      end
   end

   // ---------------- scoreboard / monitor B ----------------
   always @(negedge clk) begin
      if (rst) begin
         b_prev_acc <= 1'b0;
      end else begin
         check("b_latency", b_resp_valid, b_prev_acc);
         check("b_illegal", b_illegal, 1'b0);
         if (b_resp_valid && b_resp_ready) begin
            n_cmp++;
            assert (b_exp_q.size() > 0) else begin
               n_err++;
               $error("FAIL b_unexpected_resp observed=%0h expected=none", b_resp_result);
            end
            if (b_exp_q.size() > 0) check("b_result", 128'(b_resp_result), b_exp_q.pop_front());
         end
         if (b_req_valid && b_req_ready)
            b_exp_q.push_back(model(8, 4, b_op, 128'(b_opnd1), 128'(b_opnd2)));
         b_prev_acc <= b_req_valid && b_req_ready;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One op into an empty pipe with resp ready high: checks accept, the
   // two-cycle latency and the exact result value.
   task automatic a_single(input logic [2:0] op, input logic [127:0] x,
                           input logic [127:0] y, input logic [127:0] e,
                           input string tag);
      a_req_valid = 1'b1;
      a_op        = op;
      a_opnd1     = x;
      a_opnd2     = y;
      @(negedge clk);
      check({tag, "_ready"}, a_req_ready, 1'b1);
      tick();
      a_req_valid = 1'b0;
      @(negedge clk);
      check({tag, "_early"}, a_resp_valid, 1'b0);
      tick();
      @(negedge clk);
      check({tag, "_valid"}, a_resp_valid, 1'b1);
      check({tag, "_value"}, a_resp_result, e);
      tick();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst          = 1'b1;
      a_op         = 3'd0;
      a_opnd1      = '0;
      a_opnd2      = '0;
      a_req_valid  = 1'b0;
      a_resp_ready = 1'b1;
      b_op         = 3'd0;
      b_opnd1      = '0;
      b_opnd2      = '0;
      b_req_valid  = 1'b0;
      b_resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_resp_valid", a_resp_valid, 1'b0);
      check("rst_resp_result", a_resp_result, 128'd0);
      check("rst_busy", a_busy, 1'b0);
      check("rst_illegal", a_illegal, 1'b0);
      check("rst_b_resp_valid", b_resp_valid, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("idle_req_ready", a_req_ready, 1'b1);
      tick();

      // ADD wrap: lane0 overflows to zero without carrying into lane1
      a_single(3'd0, {64'd5, 64'hFFFF_FFFF_FFFF_FFFF}, {64'd7, 64'd1},
               {64'd12, 64'd0}, "add_wrap");
      // Signed vs unsigned on 0x8000..0 against 1
      a_single(3'd1, {2{64'h8000_0000_0000_0000}}, {2{64'd1}},
               {2{64'h8000_0000_0000_0000}}, "min_s");
      a_single(3'd3, {2{64'h8000_0000_0000_0000}}, {2{64'd1}},
               {2{64'd1}}, "min_u");
      a_single(3'd4, {2{64'h8000_0000_0000_0000}}, {2{64'd1}},
               {2{64'h8000_0000_0000_0000}}, "max_u");
      a_single(3'd2, {2{64'h8000_0000_0000_0000}}, {2{64'd1}},
               {2{64'd1}}, "max_s");
      a_single(3'd2, {64'h1234, 64'hFFFF_FFFF_FFFF_FFF0}, {64'h1234, 64'hFFFF_FFFF_FFFF_FFF0},
               {64'h1234, 64'hFFFF_FFFF_FFFF_FFF0}, "max_s_tie");
      a_single(3'd5, {64'hF0F0, 64'hFF00}, {64'h0FF0, 64'h0F0F}, {64'h00F0, 64'h0F00}, "and");
      a_single(3'd6, {64'hF0F0, 64'hFF00}, {64'h0FF0, 64'h0F0F}, {64'hFFF0, 64'hFF0F}, "or");

      // Back-to-back XOR stream: results in consecutive cycles 2..9
      for (int c = 0; c < 11; c++) begin
         a_req_valid = (c < 8);
         a_op        = 3'd7;
         a_opnd1     = 128'(c);
         a_opnd2     = 128'hF0;
         @(negedge clk);
         check("b2b_valid", a_resp_valid, (c >= 2 && c <= 9));
         if (c >= 2 && c <= 9) check("b2b_value", a_resp_result, 128'((c - 2) ^ 8'hF0));
         tick();
      end

      // Backpressure: exactly NumStages accepts, then hold
      a_resp_ready = 1'b0;
      hold_v       = '0;
      for (int c = 0; c < 6; c++) begin
         a_req_valid = 1'b1;
         a_op        = 3'd0;
         a_opnd1     = 128'(100 + c);
         a_opnd2     = 128'(c);
         @(negedge clk);
         check("bp_req_ready", a_req_ready, (c < 2));
         if (c == 2) hold_v = a_resp_result;
         if (c == 5) check("bp_hold", a_resp_result, hold_v);
         tick();
      end
      a_req_valid  = 1'b0;
      a_resp_ready = 1'b1;
      @(negedge clk);
      check("drain0_value", a_resp_result, 128'd100);
      check("drain0_busy", a_busy, 1'b1);
      tick();
      @(negedge clk);
      check("drain1_value", a_resp_result, 128'd102);
      check("drain1_busy", a_busy, 1'b1);
      tick();
      @(negedge clk);
      check("drain_done_busy", a_busy, 1'b0);
      check("drain_done_valid", a_resp_valid, 1'b0);
      tick();

      // Reset with two ops in flight: both are discarded
      a_resp_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         a_req_valid = 1'b1;
         a_op        = 3'd6;
         a_opnd1     = 128'(c + 1);
         a_opnd2     = 128'h500;
         tick();
      end
      a_req_valid = 1'b0;
      rst         = 1'b1;
      a_exp_q.delete();
      b_exp_q.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_resp_valid", a_resp_valid, 1'b0);
      check("rstmid_busy", a_busy, 1'b0);
      check("rstmid_req_ready", a_req_ready, 1'b1);
      tick();
      a_resp_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("rstmid_no_stale", a_resp_valid, 1'b0);
         tick();
      end

      // Random traffic on the 8-bit lane, single-stage instance
      for (int n = 0; n < 150; n++) begin
         b_req_valid = ($urandom_range(0, 3) != 0);
         b_op        = 3'($urandom_range(0, 7));
         b_opnd1     = $urandom();
         b_opnd2     = ($urandom_range(0, 3) == 0) ? b_opnd1 : $urandom();
         tick();
      end
      b_req_valid = 1'b0;
      repeat (3) tick();

      check("a_queue_empty", 128'(a_exp_q.size()), 128'd0);
      check("b_queue_empty", 128'(b_exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
